// File: rtl/pulse_train_generator.sv
// Pulse train generator: requests an operand pair from a producer over a soc/eoc
// handshake, then emits a pulse of numero cycles followed by gap low cycles.
module pulse_train_generator #(
  parameter int WIDTH        = 8,
  parameter bit CONT_DEFAULT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] numero,
  input  logic [WIDTH-1:0] gap,
  output logic             soc,
  input  logic             eoc,
  output logic             out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HIGH, LOW} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] gap_cnt, gap_cnt_nx;
  logic             mode_reg, mode_reg_nx;
  logic             period_end;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    gap_cnt_nx  = gap_cnt;
    mode_reg_nx = mode_reg;
    period_end  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode_reg_nx = mode;
          state_nx    = REQ;
        end
      end
      // A level-high eoc on entry is stale; only a fresh 0->1 completes a conversion.
      REQ: begin
        if (!eoc) state_nx = WAIT;
      end
      WAIT: begin
        if (eoc) begin
          cnt_nx     = numero;
          gap_cnt_nx = gap;
          if (numero != '0)   state_nx   = HIGH;
          else if (gap != '0) state_nx   = LOW;
          else                period_end = 1'b1;
        end
      end
      HIGH: begin
        cnt_nx = cnt - ONE;
        if (cnt == ONE) begin
          if (gap_cnt != '0) state_nx   = LOW;
          else               period_end = 1'b1;
        end
      end
      LOW: begin
        gap_cnt_nx = gap_cnt - ONE;
        if (gap_cnt == ONE) period_end = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (period_end) state_nx = mode_reg ? REQ : IDLE;
  end

  // Outputs are derived from the next state so they are registered yet line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      gap_cnt  <= '0;
      mode_reg <= CONT_DEFAULT;
      soc      <= 1'b0;
      out      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      gap_cnt  <= gap_cnt_nx;
      mode_reg <= mode_reg_nx;
      soc      <= (state_nx == REQ);
      out      <= (state_nx == HIGH);
      busy     <= (state_nx != IDLE);
      done     <= period_end;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: directed vector table, timeline-model random
// transactions, and a WIDTH=4 maximum-operand sequence.
module tb_pulse_train_generator;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       mode;
    logic       eoc;
    logic [7:0] numero;
    logic [7:0] gap;
    logic       soc;
    logic       out;
    logic       busy;
    logic       done;
  } vec_t;

  logic       clock;
  logic       reset, start, mode, eoc;
  logic [7:0] numero, gap;
  logic       soc, out, busy, done;

  logic       reset4, start4, mode4, eoc4;
  logic [3:0] numero4, gap4;
  logic       soc4, out4, busy4, done4;

  int total = 0;
  int bad   = 0;
  vec_t vq[$];

  // One-shot run with eoc held on REQ entry and operands changed after sampling.
  vec_t tbl [15] = '{
    '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 1'b0, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b1, 1'b1, 8'd9, 8'd9, 1'b0, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 1'b0, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 1'b0, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1},
    '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{1'b0, 1'b0, 1'b1, 1'b0, 8'd7, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0}
  };

  pulse_train_generator #(.WIDTH(8), .CONT_DEFAULT(1'b0)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .numero(numero), .gap(gap), .soc(soc), .eoc(eoc),
    .out(out), .busy(busy), .done(done)
  );

  pulse_train_generator #(.WIDTH(4), .CONT_DEFAULT(1'b0)) dut4 (
    .clock(clock), .reset(reset4), .start(start4), .mode(mode4),
    .numero(numero4), .gap(gap4), .soc(soc4), .eoc(eoc4),
    .out(out4), .busy(busy4), .done(done4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string name, input int idx, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s[%0d] got=%0b want=%0b", name, idx, act, want);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    reset  = v.rst;
    start  = v.start;
    mode   = v.mode;
    eoc    = v.eoc;
    numero = v.numero;
    gap    = v.gap;
    @(posedge clock);
    #1;
    check_output("soc",  idx, soc,  v.soc);
    check_output("out",  idx, out,  v.out);
    check_output("busy", idx, busy, v.busy);
    check_output("done", idx, done, v.done);
  endtask

  // Random inputs; expected outputs default to the idle pattern.
  function automatic vec_t rnd_vec();
    vec_t v;
    v        = '0;
    v.start  = 1'($urandom_range(0, 1));
    v.mode   = 1'($urandom_range(0, 1));
    v.eoc    = 1'($urandom_range(0, 1));
    v.numero = 8'($urandom);
    v.gap    = 8'($urandom);
    return v;
  endfunction

  function automatic vec_t with_exp(input vec_t v, input logic s, input logic o,
                                    input logic b, input logic d);
    vec_t r;
    r      = v;
    r.soc  = s;
    r.out  = o;
    r.busy = b;
    r.done = d;
    return r;
  endfunction

  task automatic add_reset();
    vec_t v;
    v       = rnd_vec();
    v.rst   = 1'b1;
    v.start = 1'b1;
    vq.push_back(v);
  endtask

  task automatic add_idle(input int k);
    vec_t v;
    for (int i = 0; i < k; i++) begin
      v       = rnd_vec();
      v.start = 1'b0;
      vq.push_back(v);
    end
  endtask

  // Timeline of one period: request phase, a stale-eoc cycles, b wait cycles,
  // then n high, g low and a single done cycle.
  task automatic add_txn(input bit first, input bit m, input int a, input int b,
                         input int n, input int g);
    vec_t v;
    if (first) begin
      v       = rnd_vec();
      v.start = 1'b1;
      v.mode  = m;
      vq.push_back(with_exp(v, 1'b1, 1'b0, 1'b1, 1'b0));
    end
    for (int i = 0; i < a; i++) begin
      v     = rnd_vec();
      v.eoc = 1'b1;
      vq.push_back(with_exp(v, 1'b1, 1'b0, 1'b1, 1'b0));
    end
    for (int i = 0; i < b; i++) begin
      v     = rnd_vec();
      v.eoc = 1'b0;
      vq.push_back(with_exp(v, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    for (int k = 0; k < n + g + 1; k++) begin
      v = rnd_vec();
      if (k == 0) begin
        v.eoc    = 1'b1;
        v.numero = 8'(n);
        v.gap    = 8'(g);
      end
      if (k < n)          vq.push_back(with_exp(v, 1'b0, 1'b1, 1'b1, 1'b0));
      else if (k < n + g) vq.push_back(with_exp(v, 1'b0, 1'b0, 1'b1, 1'b0));
      else                vq.push_back(with_exp(v, m, 1'b0, m, 1'b1));
    end
  endtask

  task automatic step4();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    bit   m;
    int   hi, lo;
    bit   got_done;

    reset = 1'b1; start = 1'b0; mode = 1'b0; eoc = 1'b0; numero = '0; gap = '0;
    reset4 = 1'b1; start4 = 1'b0; mode4 = 1'b0; eoc4 = 1'b0; numero4 = '0; gap4 = '0;

    foreach (tbl[i]) vq.push_back(tbl[i]);

    // Continuous with a zero gap, then a second conversion.
    add_txn(1'b1, 1'b1, 0, 1, 2, 0);
    add_txn(1'b0, 1'b1, 1, 2, 4, 0);
    add_reset();
    add_idle(2);
    // Zero operands and a long stale eoc.
    add_txn(1'b1, 1'b0, 0, 1, 0, 0);
    add_idle(1);
    add_txn(1'b1, 1'b0, 0, 2, 0, 2);
    add_txn(1'b1, 1'b0, 3, 1, 6, 2);

    // Reset in the fourth cycle of a 10-cycle pulse, then idle until started again.
    add_reset();
    v = rnd_vec(); v.start = 1'b1; v.mode = 1'b1;
    vq.push_back(with_exp(v, 1'b1, 1'b0, 1'b1, 1'b0));
    v = rnd_vec(); v.eoc = 1'b0;
    vq.push_back(with_exp(v, 1'b0, 1'b0, 1'b1, 1'b0));
    v = rnd_vec(); v.eoc = 1'b1; v.numero = 8'd10; v.gap = 8'd5;
    vq.push_back(with_exp(v, 1'b0, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) vq.push_back(with_exp(rnd_vec(), 1'b0, 1'b1, 1'b1, 1'b0));
    add_reset();
    add_idle(3);
    add_txn(1'b1, 1'b0, 0, 1, 1, 1);

    for (int r = 0; r < 6; r++) begin
      add_reset();
      add_idle($urandom_range(0, 2));
      m = 1'($urandom_range(0, 1));
      for (int t = 0; t < 4; t++) begin
        add_txn((m == 1'b0) || (t == 0), m,
                $urandom_range(0, 3), $urandom_range(1, 3),
                ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12),
                $urandom_range(0, 6));
        if (m == 1'b0) add_idle($urandom_range(0, 2));
      end
    end

    foreach (vq[i]) apply_stimulus(vq[i], i);

    // WIDTH=4: maximum operands must give exactly 15 high and 15 low cycles.
    reset4 = 1'b1;
    step4();
    check_output("w4_reset_busy", 0, busy4, 1'b0);
    reset4 = 1'b0; start4 = 1'b1; mode4 = 1'b0; eoc4 = 1'b0;
    step4();
    check_output("w4_soc", 0, soc4, 1'b1);
    start4 = 1'b0;
    step4();
    check_output("w4_wait_soc", 0, soc4, 1'b0);
    eoc4 = 1'b1; numero4 = 4'd15; gap4 = 4'd15;
    step4();
    numero4 = 4'd2; gap4 = 4'd1;
    hi = 0; lo = 0; got_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done4) begin
        got_done = 1'b1;
        break;
      end
      if (out4) hi++;
      else      lo++;
      step4();
    end
    total++;
    if (!got_done) begin
      bad++;
      $display("[TB] FAIL w4_done_timeout got=0 want=1");
    end
    total++;
    if (hi != 15) begin
      bad++;
      $display("[TB] FAIL w4_high_cycles got=%0d want=15", hi);
    end
    total++;
    if (lo != 15) begin
      bad++;
      $display("[TB] FAIL w4_low_cycles got=%0d want=15", lo);
    end
    step4();
    check_output("w4_idle_out",  0, out4,  1'b0);
    check_output("w4_idle_busy", 0, busy4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the width of the pulse-length and gap operands and internal counters.
REQ-002 The module SHALL have parameter CONT_DEFAULT, default 0, meaning the value of the mode register after reset.
REQ-003 The module SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port start  input  1  one-shot trigger, sampled in IDLE only.
REQ-006 The module SHALL have port mode  input  1  0 = one-shot, 1 = continuous, sampled in IDLE only.
REQ-007 The module SHALL have port numero  input  WIDTH  pulse length in clock cycles, valid while eoc=1.
REQ-008 The module SHALL have port gap  input  WIDTH  low time after the pulse in clock cycles, valid while eoc=1.
REQ-009 The module SHALL have port soc  output  1  start-of-conversion request to the producer.
REQ-010 The module SHALL have port eoc  input  1  end-of-conversion from the producer.
REQ-011 The module SHALL have port out  output  1  generated pulse.
REQ-012 The module SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 The module SHALL have port done  output  1  one-cycle strobe at the end of each pulse+gap period.

Function
REQ-014 The module SHALL register all outputs (soc, out, busy, done) and SHALL drive them from no combinational path on inputs.
REQ-015 The state machine SHALL have five states: IDLE, REQ, WAIT, HIGH, LOW.
REQ-016 IDLE: soc=0, out=0, busy=0; on start=1 the module SHALL latch mode into the mode register and go to REQ.
REQ-017 REQ: soc=1; the module SHALL stay while eoc=1 and go to WAIT on the edge where eoc=0.
REQ-018 WAIT: soc=0; the module SHALL stay while eoc=0; on the edge where eoc=1 it SHALL load CNT<=numero and GAPCNT<=gap.
REQ-019 WAIT exit on that edge: if numero!=0, go to HIGH with out<=1; if numero=0 and gap!=0, go to LOW; if both are 0, end the period (REQ-022).
REQ-020 HIGH: out SHALL be 1 for exactly numero consecutive cycles, with CNT decremented each cycle; on the edge where CNT=1, the module SHALL drop out to 0 and go to LOW if GAPCNT!=0, otherwise end the period.
REQ-021 LOW: out=0 with GAPCNT decremented each cycle; on the edge where GAPCNT=1, the module SHALL end the period.
REQ-022 End of period: done SHALL be 1 for exactly the following cycle; the next state SHALL be REQ if the mode register is 1 (soc rises in the cycle done is high), otherwise IDLE.
REQ-023 Counters SHALL be WIDTH-bit unsigned; a maximum operand (2^WIDTH-1) SHALL give exactly 2^WIDTH-1 cycles, with no wrap and no underflow.
REQ-024 Operand value 0 SHALL give 0 cycles in that phase (a zero pulse produces no out glitch).
REQ-025 While busy=1, changes on start and mode SHALL be ignored.
REQ-026 In continuous mode, clearing mode has no effect until IDLE; the only exits from continuous operation SHALL be reset.
REQ-027 numero and gap SHALL be sampled only on the REQ-018 edge, and later changes SHALL NOT affect the current period.
REQ-028 An eoc that is already 1 on entry to REQ SHALL hold the module in REQ; it SHALL NOT be taken as a completed conversion.

Reset
REQ-029 When reset=1 at a rising edge, the next state SHALL be IDLE, with soc=0, out=0, busy=0, done=0, CNT=0, GAPCNT=0, and the mode register = CONT_DEFAULT.
REQ-030 Reset SHALL take priority over every other input, including mid-pulse and mid-handshake; out SHALL be 0 in the cycle after the reset edge.
REQ-031 After reset is released, the module SHALL be idle until start=1.

Verification
REQ-032 One-shot, WIDTH=8: start with mode=0; eoc 1->0->1 with numero=5, gap=3 -> out high 5 cycles, low 3, done 1 cycle, then IDLE with soc=0.
REQ-033 Continuous: mode=1, numero=2, gap=0 -> out 1,1 then done, soc rises with done; a second conversion with numero=4 gives out high 4 cycles.
REQ-034 Zero operands: numero=0, gap=0 -> out never 1, done exactly one cycle after the eoc sampling edge; numero=0, gap=2 -> done after 2 low cycles.
REQ-035 Max operand, WIDTH=4: numero=15 -> out high exactly 15 cycles, and CNT never wraps.
REQ-036 Reset mid-HIGH with numero=10: reset at pulse cycle 4 -> out=0, soc=0, busy=0 the next cycle; stays IDLE until start.
REQ-037 Handshake robustness: eoc held 1 on REQ entry for 3 cycles -> soc stays 1 with no load; numero changed after the sample edge -> pulse length is unchanged.
